// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch controller state encoding and control bundle.
// Encoding is also decoded by the hazard unit and debug tooling, so it must stay fixed.
package pipeline_pkg;

    localparam logic [1:0] FC_IDLE = 2'b00;
    localparam logic [1:0] FC_REQ  = 2'b01;
    localparam logic [1:0] FC_DROP = 2'b10;

    typedef struct packed {
        logic imem_req;
        logic pc_write;
        logic if_id_write;
        logic flush_d;
        logic flush_e;
        logic stall_inc;
        logic redirect_inc;
    } fc_ctrl_t;

    localparam fc_ctrl_t FC_CTRL_OFF = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Latency: q reflects an increment one cycle after inc; no backpressure.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] CNT_ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch sequencing against a variable-latency imem: merges response timing, load-use and redirects.
// Latency: controls are combinational from state and inputs; backpressure: holds PC/IF_ID until imem_rvalid.
module fetch_controller
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_rvalid,
    input  logic             load_use_hazard,
    input  logic             PCSrcE,
    output logic             imem_req,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             FlushD,
    output logic             FlushE,
    output logic [CNT_W-1:0] fetch_stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic [1:0]       fsm_state
);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    fc_ctrl_t         ctrl;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] redirect_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A redirect that beats the response leaves a stale request in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FC_IDLE: state_d = FC_REQ;
            FC_REQ:  state_d = (PCSrcE && !imem_rvalid) ? FC_DROP : FC_REQ;
            FC_DROP: state_d = imem_rvalid ? FC_REQ : FC_DROP;
            default: state_d = FC_IDLE;
        endcase
    end

    always_comb begin
        ctrl = FC_CTRL_OFF;
        if (!rst) begin
            case (state_q)
                FC_IDLE: begin
                    ctrl.if_id_write = 1'b1;
                    ctrl.flush_d     = 1'b1;
                end
                FC_REQ: begin
                    ctrl.imem_req = 1'b1;
                    if (PCSrcE) begin
                        ctrl.pc_write     = 1'b1;
                        ctrl.if_id_write  = 1'b1;
                        ctrl.flush_d      = 1'b1;
                        ctrl.flush_e      = 1'b1;
                        ctrl.redirect_inc = 1'b1;
                    end else if (load_use_hazard) begin
                        ctrl.flush_e = 1'b1;
                    end else if (imem_rvalid) begin
                        ctrl.pc_write    = 1'b1;
                        ctrl.if_id_write = 1'b1;
                    end else begin
                        ctrl.if_id_write = 1'b1;
                        ctrl.flush_d     = 1'b1;
                        ctrl.stall_inc   = 1'b1;
                    end
                end
                FC_DROP: begin
                    ctrl.pc_write     = PCSrcE;
                    ctrl.if_id_write  = !load_use_hazard;
                    ctrl.flush_d      = 1'b1;
                    ctrl.flush_e      = load_use_hazard | PCSrcE;
                    ctrl.stall_inc    = 1'b1;
                    ctrl.redirect_inc = PCSrcE;
                end
                default: ctrl = FC_CTRL_OFF;
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ctrl.stall_inc),
        .q   (stall_cnt_q)
    );

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ctrl.redirect_inc),
        .q   (redirect_cnt_q)
    );

    assign imem_req        = ctrl.imem_req;
    assign PCWrite         = ctrl.pc_write;
    assign IF_ID_Write     = ctrl.if_id_write;
    assign FlushD          = ctrl.flush_d;
    assign FlushE          = ctrl.flush_e;
    assign fetch_stall_cnt = rst ? '0 : stall_cnt_q;
    assign redirect_cnt    = rst ? '0 : redirect_cnt_q;
    assign fsm_state       = rst ? FC_IDLE : state_q;

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencing controller for the Fetch stage of the pipelined RV32 core. It drives Fetch_Stage's PCWrite/IF_ID_Write plus decode/execute flush strobes against a variable-latency instruction memory. It merges three event sources:
- memory response timing
- load-use stalls from the hazard unit
- taken branches from Execute

It also keeps saturating performance counters for fetch-stall cycles and redirects.

## Interface
Parameters:
- CNT_W, 32, width of both performance counters

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- imem_rvalid  in  1  instruction for the outstanding request is valid this cycle (InstrF)
- load_use_hazard  in  1  decode must hold (from hazard detection)
- PCSrcE  in  1  branch/jump taken in Execute; PC mux selects PCTargetE
- imem_req  out  1  fetch request for address on PCF; level, held until imem_rvalid
- PCWrite  out  1  PC register enable
- IF_ID_Write  out  1  IF/ID register enable
- FlushD  out  1  clear IF/ID to bubble (effective only when IF_ID_Write=1)
- FlushE  out  1  clear ID/EX to bubble
- fetch_stall_cnt  out  CNT_W  cycles decode received a bubble due to fetch
- redirect_cnt  out  CNT_W  accepted PCSrcE redirects
- fsm_state  out  2  current state, for debug

## Operation
- States: IDLE, REQ, DROP.
- Request start: a new request starts in the first REQ cycle, and in each REQ cycle after an imem_rvalid. The PCF address is stable for the request's lifetime.
- IDLE (one cycle after reset):
  - imem_req=0, PCWrite=0, IF_ID_Write=1, FlushD=1, FlushE=0.
  - Next state is REQ.
- REQ: imem_req=1. Priority is PCSrcE > load_use_hazard > imem_rvalid > waiting.
  - PCSrcE: PCWrite=1, IF_ID_Write=1, FlushD=1, FlushE=1, redirect_cnt+1. Next is REQ if imem_rvalid (the response is squashed by FlushD), else DROP.
  - load_use_hazard: PCWrite=0, IF_ID_Write=0, FlushD=0, FlushE=1. A coincident response is discarded, and the same PC is re-requested. Next is REQ.
  - imem_rvalid: PCWrite=1, IF_ID_Write=1, no flush. Next is REQ.
  - waiting: PCWrite=0, IF_ID_Write=1, FlushD=1, FlushE=0, fetch_stall_cnt+1.
- DROP (a stale request is outstanding; PC already holds the target):
  - imem_req=0, PCWrite=0, IF_ID_Write=1, FlushD=1, fetch_stall_cnt+1.
  - load_use_hazard: IF_ID_Write=0 and FlushE=1 instead.
  - PCSrcE (defensive): PCWrite=1, FlushE=1, redirect_cnt+1; stay in DROP.
  - imem_rvalid: data discarded; next is REQ.
- Counters: saturate at all-ones and never wrap. Both may increment in the same cycle.
- Reset:
  - While rst=1: all outputs are 0 and fsm_state=IDLE encoding.
  - On the rst edge: state<=IDLE and counters<=0.
  - Reset mid-request: the memory is reset alongside the core, so no stale response is tracked across reset.

## Timing
- Outputs are combinational from the registered state and the current inputs. The only registered elements are the state and the counters.
- imem_rvalid may assert in the request-start cycle (combinational memory). With imem_rvalid tied to 1, throughput is 1 instr/cycle, identical to the current single-cycle fetch.
- Memory latency N cycles after request start gives N bubble cycles per instruction into decode.
- Branch penalty:
  - Two instructions are flushed (FlushD plus FlushE) on the PCSrcE cycle.
  - The target is requested the cycle after PCSrcE if the stale response coincided with PCSrcE.
  - Otherwise the target is requested the cycle after the stale imem_rvalid.
- Load-use stall: exactly the cycles load_use_hazard is high. PCWrite and IF_ID_Write are deasserted in those cycles, and FlushE is asserted in each.

## Structure
- Put the state encoding in shared package pipeline_pkg: localparams FC_IDLE=2'b00, FC_REQ=2'b01, FC_DROP=2'b10. The hazard unit and debug tooling use the same encoding.
- Sub-module sat_counter (parameter W; inputs clk, rst, inc; output q) is instantiated twice.
- Fetch_Stage gains FlushD as an input. Its PCSrcE/PCTargetE mux is unchanged.

## Test plan
- Reset then imem_rvalid tied 1, no hazards:
  - IDLE for 1 cycle, then PCWrite=IF_ID_Write=1 every cycle.
  - PCD steps 0,4,8,...; fetch_stall_cnt=0.
- Memory latency 2 (imem_rvalid every third cycle):
  - Each instruction is followed by 2 bubble cycles into decode (FlushD=1).
  - fetch_stall_cnt=20 after 10 instructions.
- PCSrcE with PCTargetE=0x20 while waiting, stale imem_rvalid 2 cycles later:
  - PCSrcE cycle: FlushD=FlushE=1, then DROP for 2 cycles with imem_req=0.
  - Next PCD=0x20; redirect_cnt=1.
- PCSrcE with PCTargetE=0x40 coincident with imem_rvalid:
  - No DROP; the target is requested the next cycle.
  - The stale instruction never appears in PCD.
- load_use_hazard high for 1 cycle coincident with imem_rvalid:
  - PCWrite=IF_ID_Write=0, FlushE=1.
  - The same PC is re-requested; the instruction sequence in decode has no skip or duplicate.
- rst asserted mid-REQ for 1 cycle, plus counter saturation with CNT_W=4:
  - After the rst edge: IDLE, all counters 0.
  - fetch_stall_cnt holds at 4'hF after 20 stall cycles.
